// File: rtl/uart_tx.sv
//------------------------------------------------------------------------------
// Module      : uart_tx
// Description : FIFO-fed UART transmitter (start, DATA_WIDTH bits LSB first,
//               optional even parity, one stop bit). Optional feature macro:
//               UART_TX_PARITY_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int CLKS_PER_BIT   = 104,
    parameter int BAUD_CTR_WIDTH = $clog2(CLKS_PER_BIT),
    parameter int BIT_CTR_WIDTH  = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd4,
`endif
        S_STOP   = 3'd5
    } state_t;

    localparam logic [BAUD_CTR_WIDTH-1:0] c_BAUD_LAST = BAUD_CTR_WIDTH'(CLKS_PER_BIT - 1);
    localparam logic [BIT_CTR_WIDTH-1:0]  c_BIT_LAST  = BIT_CTR_WIDTH'(DATA_WIDTH - 1);

    state_t                    r_state;
    state_t                    w_state_next;
    logic                      r_tx;
    logic                      w_tx_next;
    logic [BAUD_CTR_WIDTH-1:0] r_baud_cnt;
    logic [BAUD_CTR_WIDTH-1:0] w_baud_next;
    logic [BIT_CTR_WIDTH-1:0]  r_bit_idx;
    logic [BIT_CTR_WIDTH-1:0]  w_bit_next;
    logic [DATA_WIDTH-1:0]     r_shift_reg;
    logic [DATA_WIDTH-1:0]     w_shift_next;
    logic                      w_bit_done;
`ifdef UART_TX_PARITY_EN
    logic                      r_parity;
    logic                      w_parity_next;
`endif

    assign fifo_rd_en = n_reset && (r_state == S_IDLE) && enable && !fifo_empty;
    assign tx         = r_tx;
    assign busy       = (r_state != S_IDLE);
    assign w_bit_done = (r_baud_cnt == c_BAUD_LAST);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath: the shift register is consumed LSB first,
    // so the bit to drive next is always r_shift_reg[0].
    always_comb begin
        w_state_next  = r_state;
        w_tx_next     = r_tx;
        w_baud_next   = r_baud_cnt;
        w_bit_next    = r_bit_idx;
        w_shift_next  = r_shift_reg;
`ifdef UART_TX_PARITY_EN
        w_parity_next = r_parity;
`endif
        case (r_state)
            S_IDLE: begin
                w_tx_next   = 1'b1;
                w_baud_next = '0;
                if (fifo_rd_en) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                w_shift_next  = fifo_data;
`ifdef UART_TX_PARITY_EN
                w_parity_next = ^fifo_data;
`endif
                w_tx_next     = 1'b0;
                w_baud_next   = '0;
                w_bit_next    = '0;
                w_state_next  = S_START;
            end
            S_START: begin
                if (w_bit_done) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_tx_next    = r_shift_reg[0];
                    w_shift_next = r_shift_reg >> 1;
                    w_state_next = S_DATA;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    w_baud_next = '0;
                    if (r_bit_idx == c_BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        w_tx_next    = r_parity;
                        w_state_next = S_PARITY;
`else
                        w_tx_next    = 1'b1;
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next   = r_bit_idx + 1'b1;
                        w_tx_next    = r_shift_reg[0];
                        w_shift_next = r_shift_reg >> 1;
                    end
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_done) begin
                    w_baud_next  = '0;
                    w_tx_next    = 1'b1;
                    w_state_next = S_STOP;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (w_bit_done) begin
                    w_baud_next  = '0;
                    w_tx_next    = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_baud_next = r_baud_cnt + 1'b1;
                end
            end
            default: begin
                w_tx_next    = 1'b1;
                w_baud_next  = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_tx        <= 1'b1;
            r_baud_cnt  <= '0;
            r_bit_idx   <= '0;
            r_shift_reg <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity    <= 1'b0;
`endif
        end else begin
            r_tx        <= w_tx_next;
            r_baud_cnt  <= w_baud_next;
            r_bit_idx   <= w_bit_next;
            r_shift_reg <= w_shift_next;
`ifdef UART_TX_PARITY_EN
            r_parity    <= w_parity_next;
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
//------------------------------------------------------------------------------
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx with a queue-based FIFO model
//               and a per-bit frame reference (honours UART_TX_PARITY_EN).
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_tx;

    localparam int CPB = 4;
    localparam int DW  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB  = DW + 3;
`else
    localparam int NB  = DW + 2;
`endif

    logic          clk        = 1'b0;
    logic          n_reset    = 1'b0;
    logic          enable     = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data  = '0;
    logic          fifo_rd_en;
    logic          tx;
    logic          busy;

    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [DW-1:0] fifo_q[$];

    uart_tx #(
        .DATA_WIDTH   (DW),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .enable     (enable),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Synchronous FIFO model: registered read data, empty flag after the edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd_en && fifo_q.size() > 0) begin
            fifo_data <= fifo_q.pop_front();
        end
        fifo_empty <= (fifo_q.size() == 0);
    end

    // Line level of frame bit k: start, payload LSB first, [even parity], stop.
    function automatic logic exp_bit(input logic [DW-1:0] d, input int k);
        if (k == 0)
            return 1'b0;
        if (k >= 1 && k <= DW)
            return logic'((d >> (k - 1)) & 1);
        if (k == NB - 1)
            return 1'b1;
        return logic'($countones(d) % 2);
    endfunction

    task automatic push(input logic [DW-1:0] b);
        @(posedge clk);
        #1;
        fifo_q.push_back(b);
    endtask

    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if ({tx, busy, fifo_rd_en} !== 3'b100) begin
                failures++;
                $display("FAIL %s cycle=%0d tx/busy/rd_en actual=%b required=100", name, i, {tx, busy, fifo_rd_en});
            end
        end
    endtask

    // Waits for the read pulse, then checks LOAD and every cycle of the frame.
    task automatic expect_frame(input logic [DW-1:0] b, input int drop_at, output int rd_cyc);
        bit seen = 1'b0;
        rd_cyc = -1;
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            seen = fifo_rd_en;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rd_en_timeout byte=%02h actual=no_read required=read", b);
            return;
        end
        rd_cyc = cyc;
        @(negedge clk);
        checks++;
        if ({tx, busy, fifo_rd_en} !== 3'b110) begin
            failures++;
            $display("FAIL load_cycle byte=%02h tx/busy/rd_en actual=%b required=110", b, {tx, busy, fifo_rd_en});
        end
        for (int k = 0; k < NB; k++) begin
            for (int c = 0; c < CPB; c++) begin
                @(negedge clk);
                if (k == drop_at && c == 0) enable = 1'b0;
                checks++;
                if ({tx, busy, fifo_rd_en} !== {exp_bit(b, k), 2'b10}) begin
                    failures++;
                    $display("FAIL frame_bit byte=%02h bit=%0d cyc=%0d tx/busy/rd_en actual=%b required=%b",
                             b, k, c, {tx, busy, fifo_rd_en}, {exp_bit(b, k), 2'b10});
                end
            end
        end
    endtask

    task automatic test_reset;
        enable = 1'b1;
        @(negedge clk);
        checks++;
        if ({tx, busy, fifo_rd_en} !== 3'b100) begin
            failures++;
            $display("FAIL reset_hold tx/busy/rd_en actual=%b required=100", {tx, busy, fifo_rd_en});
        end
        @(posedge clk);
        #1 n_reset = 1'b1;
        check_idle("reset_idle", 100);
    endtask

    task automatic test_single;
        int r;
        push(8'hA5);
        expect_frame(8'hA5, -1, r);
        check_idle("single_after", 10);
    endtask

    task automatic test_parity_bytes;
        int r;
        push(8'hA5);
        expect_frame(8'hA5, -1, r);
        check_idle("parity_gap", 3);
        push(8'h07);
        expect_frame(8'h07, -1, r);
        check_idle("parity_after", 5);
    endtask

    task automatic test_back_to_back;
        int r1, r2;
        push(8'h00);
        push(8'hFF);
        expect_frame(8'h00, -1, r1);
        expect_frame(8'hFF, -1, r2);
        checks++;
        if (r2 - r1 !== NB * CPB + 2) begin
            failures++;
            $display("FAIL b2b_spacing actual=%0d required=%0d", r2 - r1, NB * CPB + 2);
        end
        check_idle("b2b_no_third_read", 50);
    endtask

    task automatic test_random;
        int r;
        logic [DW-1:0] b;
        for (int i = 0; i < 6; i++) begin
            b = DW'($urandom);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            push(b);
            expect_frame(b, -1, r);
        end
        check_idle("random_after", 5);
    endtask

    task automatic test_enable_drop;
        int r;
        logic [DW-1:0] b1, b2;
        b1 = DW'($urandom);
        b2 = DW'($urandom);
        push(b1);
        push(b2);
        expect_frame(b1, 3, r);
        check_idle("enable_low_no_read", 60);
        @(posedge clk);
        #1 enable = 1'b1;
        expect_frame(b2, -1, r);
        check_idle("enable_after", 5);
    endtask

    task automatic test_reset_mid;
        int r;
        bit seen = 1'b0;
        logic [DW-1:0] b1, b2;
        b1 = DW'($urandom);
        b2 = DW'($urandom);
        push(b1);
        push(b2);
        for (int n = 0; n < 300 && !seen; n++) begin
            @(negedge clk);
            seen = fifo_rd_en;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL rstmid_timeout actual=no_read required=read");
        end
        // LOAD, start bit, data bits 0..2, then two cycles into data bit 3
        repeat (1 + CPB + 3 * CPB + 2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_inflight busy actual=%b required=1", busy);
        end
        #2 n_reset = 1'b0;
        #1;
        checks++;
        if ({tx, busy, fifo_rd_en} !== 3'b100) begin
            failures++;
            $display("FAIL rstmid_async tx/busy/rd_en actual=%b required=100", {tx, busy, fifo_rd_en});
        end
        repeat (3) @(negedge clk);
        checks++;
        if ({tx, busy, fifo_rd_en} !== 3'b100) begin
            failures++;
            $display("FAIL rstmid_hold tx/busy/rd_en actual=%b required=100", {tx, busy, fifo_rd_en});
        end
        @(posedge clk);
        #1 n_reset = 1'b1;
        expect_frame(b2, -1, r);
        check_idle("rstmid_after", 10);
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity_bytes();
        test_back_to_back();
        test_random();
        test_enable_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
